// File: rtl/lx32_pkg.sv
// Shared types and constants for the lx32 writeback path.
package lx32_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;

    typedef logic [4:0] reg_addr_t;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: req[0]=ALU, req[1]=LSU.
// A lone requester is granted at once; on a tie the source not granted
// last wins. The history flop moves only when something is granted.
module rr_arbiter2
    import lx32_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    wb_src_e last_grant;

    // Combinational grant from the request pair and the grant history
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_grant == WB_LSU) ? 2'b01 : 2'b10;
        end
    end

    // Remember who was served; reset favours ALU on the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= WB_LSU;
        end else if (|gnt) begin
            last_grant <= gnt[1] ? WB_LSU : WB_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler for the lx32 register file write port.
// Arbitrates ALU/LSU writeback, registers the single write port,
// keeps the in-flight destination scoreboard and stalls issue on
// RAW/WAW hazards. There is no forwarding: a consumer waits until the
// write has landed in the register file.
module regfile_wb_scheduler #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      iss_rs1,
    input  logic [4:0]      iss_rs2,
    output logic            iss_stall,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            rf_we,
    output logic [4:0]      rf_addr_rd,
    output logic [XLEN-1:0] rf_data_rd,
    output logic [NREG-1:0] pending,
    output logic            err_spur
);

    import lx32_pkg::*;

    logic [1:0]      req;
    logic [1:0]      gnt;
    logic            xfer;
    reg_addr_t       sel_rd;
    logic [XLEN-1:0] sel_data;
    logic            iss_fire;
    logic [NREG-1:0] pending_nxt;

    assign req = {lsu_valid, alu_valid};

    rr_arbiter2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    assign alu_ready = gnt[0];
    assign lsu_ready = gnt[1];
    assign xfer      = |gnt;

    // Mux the granted requester's destination and payload
    always_comb begin
        sel_rd   = alu_rd;
        sel_data = alu_data;
        if (gnt[1]) begin
            sel_rd   = lsu_rd;
            sel_data = lsu_data;
        end
    end

    // Hazard stall: any nonzero source or destination still in flight
    assign iss_stall = iss_valid &
                       ((pending[iss_rs1] & (iss_rs1 != 5'd0)) |
                        (pending[iss_rs2] & (iss_rs2 != 5'd0)) |
                        (pending[iss_rd]  & (iss_rd  != 5'd0)));

    assign iss_fire = iss_valid & ~iss_stall & (iss_rd != 5'd0);

    // Next scoreboard: retire the committing write, then apply a new
    // reservation so a same-edge set on the same register wins
    always_comb begin
        pending_nxt = pending;
        if (rf_we) begin
            pending_nxt[rf_addr_rd] = 1'b0;
        end
        if (iss_fire) begin
            pending_nxt[iss_rd] = 1'b1;
        end
    end

    // Registered write port; a transfer to x0 consumes the slot silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we      <= 1'b0;
            rf_addr_rd <= '0;
            rf_data_rd <= '0;
        end else begin
            rf_we <= xfer & (sel_rd != 5'd0);
            if (xfer) begin
                rf_addr_rd <= sel_rd;
                rf_data_rd <= sel_data;
            end
        end
    end

    // Scoreboard register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // Sticky flag for writebacks to registers nobody reserved
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_spur <= 1'b0;
        end else if (xfer && (sel_rd != 5'd0) && !pending[sel_rd]) begin
            err_spur <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Testbench for regfile_wb_scheduler: directed scenarios with a
// scoreboard queue of expected register-file writes.
module tb_regfile_wb_scheduler;

    localparam int XLEN = 32;
    localparam int NREG = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            iss_valid = 1'b0;
    logic [4:0]      iss_rd = '0, iss_rs1 = '0, iss_rs2 = '0;
    logic            iss_stall;
    logic            alu_valid = 1'b0;
    logic            alu_ready;
    logic [4:0]      alu_rd = '0;
    logic [XLEN-1:0] alu_data = '0;
    logic            lsu_valid = 1'b0;
    logic            lsu_ready;
    logic [4:0]      lsu_rd = '0;
    logic [XLEN-1:0] lsu_data = '0;
    logic            rf_we;
    logic [4:0]      rf_addr_rd;
    logic [XLEN-1:0] rf_data_rd;
    logic [NREG-1:0] pending;
    logic            err_spur;

    typedef struct {
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
    } wb_t;

    wb_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    regfile_wb_scheduler #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk        (clk),
        .rst        (rst),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .iss_rs1    (iss_rs1),
        .iss_rs2    (iss_rs2),
        .iss_stall  (iss_stall),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .rf_we      (rf_we),
        .rf_addr_rd (rf_addr_rd),
        .rf_data_rd (rf_data_rd),
        .pending    (pending),
        .err_spur   (err_spur)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        iss_valid = 1'b0;
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
        repeat (2) tick();
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        iss_valid = 1'b1; iss_rd = rd; iss_rs1 = rs1; iss_rs2 = rs2;
        #1;
        check_eq("issue_nostall", iss_stall, 1'b0);
        tick();
        iss_valid = 1'b0; iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
    endtask

    // Scoreboard: every observed write must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && rf_we) begin
            if (exp_q.size() == 0) begin
                check_eq("wb_unexpected", 1'b1, 1'b0);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                check_eq("wb_addr", rf_addr_rd, e.addr);
                check_eq("wb_data", rf_data_rd, e.data);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        check_eq("rst_pending", pending, '0);
        check_eq("rst_we", rf_we, 1'b0);
        check_eq("rst_addr", rf_addr_rd, 5'd0);
        check_eq("rst_data", rf_data_rd, '0);
        check_eq("rst_err", err_spur, 1'b0);
        check_eq("rst_stall", iss_stall, 1'b0);

        // 1. Single ALU write
        issue(5'd5, 5'd0, 5'd0);
        check_eq("t1_pend_set", pending, 32'h0000_0020);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hABCD_1234;
        exp_q.push_back('{5'd5, 32'hABCD_1234});
        #1;
        check_eq("t1_alu_ready", alu_ready, 1'b1);
        check_eq("t1_lsu_ready", lsu_ready, 1'b0);
        tick();
        alu_valid = 1'b0;
        check_eq("t1_we", rf_we, 1'b1);
        check_eq("t1_pend_n1", pending[5], 1'b1);
        tick();
        check_eq("t1_pend_n2", pending[5], 1'b0);
        check_eq("t1_err", err_spur, 1'b0);

        // 2. Tie from reset: ALU first, LSU next
        do_reset();
        issue(5'd3, 5'd0, 5'd0);
        issue(5'd4, 5'd0, 5'd0);
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1111_0003;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h2222_0004;
        exp_q.push_back('{5'd3, 32'h1111_0003});
        exp_q.push_back('{5'd4, 32'h2222_0004});
        #1;
        check_eq("t2_gnt0", {lsu_ready, alu_ready}, 2'b01);
        tick();
        alu_valid = 1'b0;
        #1;
        check_eq("t2_gnt1", {lsu_ready, alu_ready}, 2'b10);
        check_eq("t2_we0", rf_we, 1'b1);
        tick();
        lsu_valid = 1'b0;
        check_eq("t2_we1", rf_we, 1'b1);
        tick();
        check_eq("t2_we_off", rf_we, 1'b0);
        check_eq("t2_pend", pending, '0);
        check_eq("t2_err", err_spur, 1'b0);

        // Round-robin history: LSU went last, so a fresh tie goes to ALU
        issue(5'd10, 5'd0, 5'd0);
        issue(5'd11, 5'd0, 5'd0);
        lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 32'h0000_00BB;
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h0000_00AA;
        exp_q.push_back('{5'd10, 32'h0000_00AA});
        exp_q.push_back('{5'd11, 32'h0000_00BB});
        #1;
        check_eq("t2_rr_gnt", {lsu_ready, alu_ready}, 2'b01);
        tick();
        alu_valid = 1'b0;
        tick();
        lsu_valid = 1'b0;
        tick();
        check_eq("t2_rr_pend", pending, '0);

        // 3. RAW on x7, plus WAW on x8
        issue(5'd7, 5'd0, 5'd0);
        iss_valid = 1'b1; iss_rd = 5'd8; iss_rs1 = 5'd7; iss_rs2 = 5'd0;
        #1;
        check_eq("t3_stall_pre", iss_stall, 1'b1);
        tick();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h7777_7777;
        exp_q.push_back('{5'd7, 32'h7777_7777});
        #1;
        check_eq("t3_stall_n", iss_stall, 1'b1);
        tick();
        alu_valid = 1'b0;
        check_eq("t3_stall_n1", iss_stall, 1'b1);
        tick();
        check_eq("t3_stall_n2", iss_stall, 1'b0);
        tick();
        iss_valid = 1'b0; iss_rd = 5'd0; iss_rs1 = 5'd8;
        #1;
        check_eq("t3_pend8", pending, 32'h0000_0100);
        check_eq("t3_novalid", iss_stall, 1'b0);
        iss_valid = 1'b1; iss_rd = 5'd8; iss_rs1 = 5'd0;
        #1;
        check_eq("t3_waw", iss_stall, 1'b1);
        iss_valid = 1'b0; iss_rd = 5'd0;

        // 4. LSU write to x0 consumes the slot without writing
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFFFF_FFFF;
        #1;
        check_eq("t4_lsu_ready", lsu_ready, 1'b1);
        tick();
        lsu_valid = 1'b0;
        check_eq("t4_we", rf_we, 1'b0);
        tick();
        check_eq("t4_err", err_spur, 1'b0);
        check_eq("t4_pend", pending, 32'h0000_0100);

        // 5. Commit to x9 and new reservation of x9 on the same edge
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0909_0909;
        exp_q.push_back('{5'd9, 32'h0909_0909});
        tick();
        alu_valid = 1'b0;
        check_eq("t5_we", rf_we, 1'b1);
        check_eq("t5_err_spur", err_spur, 1'b1);
        issue(5'd9, 5'd0, 5'd0);
        check_eq("t5_pend9", pending, 32'h0000_0300);

        // 6. Async reset while a write is registered
        do_reset();
        issue(5'd5, 5'd0, 5'd0);
        issue(5'd7, 5'd0, 5'd0);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h5555_AAAA;
        exp_q.push_back('{5'd5, 32'h5555_AAAA});
        tick();
        alu_valid = 1'b0;
        check_eq("t6_we_pre", rf_we, 1'b1);
        check_eq("t6_pend_pre", pending, 32'h0000_00A0);
        rst = 1'b1;
        #1;
        check_eq("t6_we", rf_we, 1'b0);
        check_eq("t6_pend", pending, '0);
        check_eq("t6_err", err_spur, 1'b0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        check_eq("t6_we_after", rf_we, 1'b0);

        check_eq("wb_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
